// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch front end.
package imem_pkg;

   localparam logic [31:0] BASE_ADDR = 32'h0040_0000;
   localparam int unsigned IMEM_AW   = 11;
   localparam logic [31:0] IMEM_SPAN = 32'd8192;
   localparam int unsigned ENTRY_W   = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   // One prefetch queue entry: the PC travels with its instruction word.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // A PC is fetchable when word aligned and inside the ROM byte window.
   function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] base);
      logic [31:0] off;
      off = pc - base;
      return (pc[1:0] == 2'b00) && (off < IMEM_SPAN);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: power-of-two deep circular buffer with flush.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;

   // Next-state: flush wins; pointers wrap naturally at the power-of-two depth.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
   end

   // Storage, pointers and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks the ROM into a prefetch queue,
// handles redirects and flags out-of-range or misaligned fetch PCs.
module imem_fetch_ctrl #(
   parameter logic [31:0] BASE_ADDR = imem_pkg::BASE_ADDR,
   parameter int unsigned QDEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [10:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fault
);

   import imem_pkg::*;

   // QDEPTH must be a power of two, at least 2, for pointer wrap to work.
   localparam int unsigned CW = $clog2(QDEPTH) + 1;

   fetch_state_e       state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
   logic               fault_q, fault_d;

   logic               pc_ok;
   logic               redir_ok;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CW-1:0]      fifo_count;
   fetch_entry_t       wr_entry;
   fetch_entry_t       head_entry;

   // Handshake decode: redirect cycles never push, but a pop still retires.
   always_comb begin
      pc_ok          = pc_legal(fetch_pc_q, BASE_ADDR);
      redir_ok       = pc_legal(redirect_pc, BASE_ADDR);
      pop            = ~fifo_empty & out_ready;
      push           = (state_q == ST_RUN) & pc_ok & ~redirect_valid &
                       ((fifo_count < CW'(QDEPTH)) | pop);
      wr_entry.pc    = fetch_pc_q;
      wr_entry.instr = imem_data;
   end

   // Next state, next fetch PC and registered outputs.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         if (!redir_ok) begin
            state_d = ST_FAULT;
         end else begin
            case (state_q)
               ST_IDLE:  state_d = ST_IDLE;
               ST_RUN:   state_d = enable ? ST_RUN : ST_IDLE;
               ST_FAULT: state_d = ST_RUN;
               default:  state_d = ST_IDLE;
            endcase
         end
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         case (state_q)
            ST_IDLE:  state_d = enable ? ST_RUN : ST_IDLE;
            ST_RUN: begin
               if (!pc_ok)       state_d = ST_FAULT;
               else if (!enable) state_d = ST_IDLE;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
         endcase
      end
      imem_addr_d = IMEM_AW'((fetch_pc_d - BASE_ADDR) >> 2);
      fault_d     = (state_d == ST_FAULT);
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         fetch_pc_q  <= BASE_ADDR;
         imem_addr_q <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         imem_addr_q <= imem_addr_d;
         fault_q     <= fault_d;
      end
   end

   fetch_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (wr_entry),
      .rdata (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Queue status flags must stay consistent with the occupancy count.
   a_full_consistent: assert property (@(posedge clk) disable iff (rst)
      fifo_full == (fifo_count == CW'(QDEPTH)));

   assign imem_addr = imem_addr_q;
   assign out_valid = ~fifo_empty;
   assign out_instr = head_entry.instr;
   assign out_pc    = head_entry.pc;
   assign fault     = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: ROM word k holds value k; expected
// deliveries are queued per scenario and retired as the DUT hands them out.
module tb_imem_fetch_ctrl;

   localparam logic [31:0] BASE = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [10:0] imem_addr;
   logic [31:0] imem_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fault;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_q [$];
   logic [63:0] exp_e;

   always #5 clk = ~clk;

   assign imem_data = {21'd0, imem_addr};

   imem_fetch_ctrl #(
      .BASE_ADDR (BASE),
      .QDEPTH    (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fault          (fault)
   );

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (imem_addr !== 11'd0) begin n_err++; $display("FAIL rst_imem_addr: got %h want 0", imem_addr); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_instr !== 32'd0) begin n_err++; $display("FAIL rst_out_instr: got %h want 0", out_instr); end
      n_cmp++; if (out_pc !== 32'd0) begin n_err++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", fault); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_fetch: got %b want 0", out_valid); end
   endtask

   task automatic test_stream();
      exp_q.delete();
      for (int k = 0; k < 8; k++) exp_q.push_back({BASE + 32'(4 * k), 32'(k)});
      enable = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_first_cycle: got %b want 0", out_valid); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL stream_%0d: valid=%b queued=%0d", i, out_valid, exp_q.size());
         end else begin
            exp_e = exp_q.pop_front();
            if ({out_pc, out_instr} !== exp_e) begin n_err++; $display("FAIL stream_%0d: got %h want %h", i, {out_pc, out_instr}, exp_e); end
         end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = BASE;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_flushed: got %b want 0", out_valid); end
      repeat (10) @(negedge clk);
      n_cmp++; if (imem_addr !== 11'd4) begin n_err++; $display("FAIL bp_imem_addr: got %0d want 4", imem_addr); end
      exp_q.delete();
      for (int k = 0; k < 8; k++) exp_q.push_back({BASE + 32'(4 * k), 32'(k)});
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL bp_drain_%0d: valid=%b queued=%0d", i, out_valid, exp_q.size());
         end else begin
            exp_e = exp_q.pop_front();
            if ({out_pc, out_instr} !== exp_e) begin n_err++; $display("FAIL bp_drain_%0d: got %h want %h", i, {out_pc, out_instr}, exp_e); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_redirect_flush();
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = BASE + 32'h100;
      @(negedge clk);
      redirect_valid = 1'b0; out_ready = 1'b1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble: got %b want 0", out_valid); end
      exp_q.delete();
      for (int k = 64; k < 68; k++) exp_q.push_back({BASE + 32'(4 * k), 32'(k)});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL redir_%0d: valid=%b queued=%0d", i, out_valid, exp_q.size());
         end else begin
            exp_e = exp_q.pop_front();
            if ({out_pc, out_instr} !== exp_e) begin n_err++; $display("FAIL redir_%0d: got %h want %h", i, {out_pc, out_instr}, exp_e); end
         end
      end
   endtask

   task automatic test_end_of_mem();
      redirect_valid = 1'b1; redirect_pc = BASE + 32'h1FFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL eom_no_early_fault: got %b want 0", fault); end
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, BASE + 32'h1FFC, 32'd2047}) begin
         n_err++; $display("FAIL eom_last_word: got %b/%h/%0d want 1/%h/2047", out_valid, out_pc, out_instr, BASE + 32'h1FFC);
      end
      @(negedge clk);
      n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL eom_fault: got %b want 1", fault); end
      repeat (3) @(negedge clk);
      n_cmp++; if ({fault, out_valid} !== 2'b10) begin n_err++; $display("FAIL eom_no_push: fault/valid got %b want 10", {fault, out_valid}); end
      redirect_valid = 1'b1; redirect_pc = BASE;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL eom_recover: got %b want 0", fault); end
      exp_q.delete();
      for (int k = 0; k < 2; k++) exp_q.push_back({BASE + 32'(4 * k), 32'(k)});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL eom_resume_%0d: valid=%b queued=%0d", i, out_valid, exp_q.size());
         end else begin
            exp_e = exp_q.pop_front();
            if ({out_pc, out_instr} !== exp_e) begin n_err++; $display("FAIL eom_resume_%0d: got %h want %h", i, {out_pc, out_instr}, exp_e); end
         end
      end
   endtask

   task automatic test_misaligned_and_reset();
      redirect_valid = 1'b1; redirect_pc = BASE + 32'd2;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_cmp++; if ({fault, out_valid} !== 2'b10) begin n_err++; $display("FAIL misalign_fault: fault/valid got %b want 10", {fault, out_valid}); end
      repeat (3) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL misalign_no_push: got %b want 0", out_valid); end
      redirect_valid = 1'b1; redirect_pc = BASE + 32'h100; out_ready = 1'b0;
      @(negedge clk);
      redirect_valid = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp++; if ({out_valid, out_pc} !== {1'b1, BASE + 32'h100}) begin n_err++; $display("FAIL prereset_head: got %b/%h want 1/%h", out_valid, out_pc, BASE + 32'h100); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({imem_addr, out_valid, out_instr, out_pc, fault} !== {11'd0, 1'b0, 32'd0, 32'd0, 1'b0}) begin
         n_err++; $display("FAIL async_reset: addr=%h valid=%b instr=%h pc=%h fault=%b want all 0", imem_addr, out_valid, out_instr, out_pc, fault);
      end
      enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if ({out_valid, imem_addr} !== {1'b0, 11'd0}) begin n_err++; $display("FAIL postreset_idle: valid/addr got %b/%h want 0/0", out_valid, imem_addr); end
   endtask

   task automatic test_idle_redirect_flush_pop();
      redirect_valid = 1'b1; redirect_pc = BASE + 32'h200;
      @(negedge clk);
      redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({imem_addr, out_valid, fault} !== {11'd128, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL idle_redirect: addr=%0d valid=%b fault=%b want 128/0/0", imem_addr, out_valid, fault);
      end
      enable = 1'b1; out_ready = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp++; if ({out_valid, out_pc, out_instr} !== {1'b1, BASE + 32'h200, 32'd128}) begin
         n_err++; $display("FAIL full_head: got %b/%h/%0d want 1/%h/128", out_valid, out_pc, out_instr, BASE + 32'h200);
      end
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = BASE + 32'h40;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flushpop_empty: got %b want 0", out_valid); end
      exp_q.delete();
      for (int k = 16; k < 18; k++) exp_q.push_back({BASE + 32'(4 * k), 32'(k)});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL flushpop_%0d: valid=%b queued=%0d", i, out_valid, exp_q.size());
         end else begin
            exp_e = exp_q.pop_front();
            if ({out_pc, out_instr} !== exp_e) begin n_err++; $display("FAIL flushpop_%0d: got %h want %h", i, {out_pc, out_instr}, exp_e); end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_flush();
      test_end_of_mem();
      test_misaligned_and_reset();
      test_idle_redirect_flush_pop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
